param_register_bank: RTL and testbench
======================================

# param_register_bank

Parametrised register bank for the EV22 datapath. It provides general-purpose registers, synchronised read-only input ports, write-only-strobed output ports and the working register W, all in one address space. It has two combinational read ports (A/B) and one clocked write port (C). It also has a memory-load path into W, with conflict detection and optional write-to-read forwarding. It sits between the control unit's bus selectors and the ALU, in the same position as the current register bank.

## Interface
- DATA_W, 16: register width in bits
- NUM_GPR, 28: number of general-purpose registers
- NUM_PI, 2: number of input port registers (read-only)
- NUM_PO, 2: number of output port registers
- ADDR_W, 6: selector width; must satisfy 2^ADDR_W > NUM_GPR+NUM_PI+NUM_PO
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- rd_a_sel  in  ADDR_W  read port A address
- rd_b_sel  in  ADDR_W  read port B address
- rd_a_data  out  DATA_W  read port A data (combinational)
- rd_b_data  out  DATA_W  read port B data (combinational)
- wr_en  in  1  write port C enable
- wr_sel  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- mem_rd_valid  in  1  memory read data valid; load into W
- mem_rd_data  in  DATA_W  memory read data
- pi  in  NUM_PI*DATA_W  external input ports, asynchronous; port i at bits [i*DATA_W +: DATA_W]
- po  out  NUM_PO*DATA_W  output port registers, same packing as pi
- po_strobe  out  NUM_PO  one-cycle pulse per output port updated
- w_out  out  DATA_W  working register W
- wr_err  out  1  one-cycle pulse on an illegal write
- mem_conflict  out  1  one-cycle pulse when a memory load is dropped

## Operation
- Address map:
  - GPR i at i
  - PI j at NUM_GPR+j
  - PO k at NUM_GPR+NUM_PI+k
  - W at WADDR = NUM_GPR+NUM_PI+NUM_PO
  - addresses above WADDR are unmapped
- Reads:
  - Mux of the addressed register; PI addresses return the synchronised value.
  - PO and W addresses read back their register.
  - Unmapped addresses return 0.
- Writes with wr_en=1, at the clock edge:
  - GPR, PO or W address: register loads wr_data.
  - PI address or unmapped address: no register changes; wr_err=1 next cycle.
  - wr_en=0: nothing is written, whatever wr_sel holds. There is no default write to W.
- Memory load:
  - mem_rd_valid=1 loads mem_rd_data into W.
  - If wr_en=1 and wr_sel=WADDR in the same cycle, the bus write wins, the memory data is discarded and mem_conflict=1 next cycle.
- Output ports:
  - A write to PO k sets po_strobe[k]=1 for exactly one cycle, aligned with the new po value.
  - Rewriting the same value still strobes.
- Input ports: each PI word passes through a 2-flop synchroniser per bit before it is visible.
- Reset values:
  - All GPRs, PO registers, W and both synchroniser stages are 0.
  - po_strobe, wr_err and mem_conflict are 0.
  - Reset has priority over wr_en and mem_rd_valid in the same cycle.

## Timing
- Write to read: value written at edge N is visible on rd_a/rd_b after edge N. Without forwarding, reads during cycle N return the old value.
- PI latency: a change on pi appears on the read ports after 2 clock edges, plus up to 1 edge of metastability resolution.
- po, po_strobe, wr_err and mem_conflict are all registered and change 1 edge after the triggering write.
- Back-to-back writes to the same register: the last write wins; every PO write produces its own strobe.
- Reset mid-operation: a write presented in the reset cycle is lost; normal operation resumes on the first edge with reset=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wr_en=1 and wr_sel is a GPR, PO or W address equal to rd_x_sel, rd_x_data returns wr_data combinationally in the same cycle.
  - A pending W memory load (mem_rd_valid=1 without a bus write to W) is forwarded to reads of WADDR the same way.
  - Writes to PI or unmapped addresses are never forwarded.
- Not defined: reads always return the stored register value; no paths from wr_data or mem_rd_data to the read ports.

## Test plan
- Reset, write GPR 5 = 0x1234, read A=5, B=5 -> both 0x1234 from the next cycle; all other GPRs read 0; with REGFILE_BYPASS_EN, 0x1234 is also visible in the write cycle.
- Write 0xBEEF to addr 28 (PI0) and to addr 40 (unmapped), with pi[15:0]=0x00AA -> wr_err pulses once per write; addr 28 reads 0x00AA two edges after pi settles; addr 40 reads 0.
- Write 0x0F0F to addr 30 (PO0) twice in a row -> po[15:0]=0x0F0F; po_strobe[0] high for two consecutive cycles; po_strobe[1]=0.
- mem_rd_valid=1 with mem_rd_data=0x5555, no bus write -> w_out=0x5555 next cycle; then mem_rd_valid with 0x1111 and bus write of 0x2222 to addr 32 in the same cycle -> w_out=0x2222, mem_conflict pulses.
- Load W=0x00FF, then wr_en=0 with wr_sel=32 and wr_data=0 -> w_out stays 0x00FF.
- Write 0x7777 to GPR 3 and assert reset in the same cycle -> GPR 3 reads 0, no strobes or error pulses; a write to GPR 3 after release is stored normally.

Source files
------------

// File: rtl/param_register_bank.sv
// EV22 register bank: GPRs, synchronised input ports, strobed output ports and W,
// two combinational read ports, one write port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module param_register_bank #(
    parameter int DATA_W  = 16,
    parameter int NUM_GPR = 28,
    parameter int NUM_PI  = 2,
    parameter int NUM_PO  = 2,
    parameter int ADDR_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rd_a_sel,
    input  logic [ADDR_W-1:0]        rd_b_sel,
    output logic [DATA_W-1:0]        rd_a_data,
    output logic [DATA_W-1:0]        rd_b_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data,
    input  logic [NUM_PI*DATA_W-1:0] pi,
    output logic [NUM_PO*DATA_W-1:0] po,
    output logic [NUM_PO-1:0]        po_strobe,
    output logic [DATA_W-1:0]        w_out,
    output logic                     wr_err,
    output logic                     mem_conflict
);

    localparam logic [ADDR_W-1:0] PI_BASE = ADDR_W'(NUM_GPR);
    localparam logic [ADDR_W-1:0] PO_BASE = ADDR_W'(NUM_GPR + NUM_PI);
    localparam logic [ADDR_W-1:0] W_ADDR  = ADDR_W'(NUM_GPR + NUM_PI + NUM_PO);

    logic [DATA_W-1:0] gpr        [NUM_GPR];
    logic [DATA_W-1:0] po_reg     [NUM_PO];
    logic [DATA_W-1:0] pi_sync_p0 [NUM_PI];
    logic [DATA_W-1:0] pi_sync_p1 [NUM_PI];
    logic [DATA_W-1:0] w_reg;

    logic wr_gpr;
    logic wr_po;
    logic wr_w;
    logic wr_bad;

    function automatic logic is_gpr(input logic [ADDR_W-1:0] sel);
        return sel < PI_BASE;
    endfunction

    function automatic logic is_po(input logic [ADDR_W-1:0] sel);
        return (sel >= PO_BASE) && (sel < W_ADDR);
    endfunction

    function automatic logic is_w(input logic [ADDR_W-1:0] sel);
        return sel == W_ADDR;
    endfunction

    // PI and unmapped addresses are not writable; they only raise wr_err
    assign wr_gpr = wr_en && is_gpr(wr_sel);
    assign wr_po  = wr_en && is_po(wr_sel);
    assign wr_w   = wr_en && is_w(wr_sel);
    assign wr_bad = wr_en && !(is_gpr(wr_sel) || is_po(wr_sel) || is_w(wr_sel));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            for (int k = 0; k < NUM_PO; k++) po_reg[k] <= '0;
            for (int j = 0; j < NUM_PI; j++) begin
                pi_sync_p0[j] <= '0;
                pi_sync_p1[j] <= '0;
            end
            w_reg        <= '0;
            po_strobe    <= '0;
            wr_err       <= 1'b0;
            mem_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (wr_gpr && (wr_sel == ADDR_W'(i))) gpr[i] <= wr_data;
            end
            for (int k = 0; k < NUM_PO; k++) begin
                if (wr_po && (wr_sel == PO_BASE + ADDR_W'(k))) begin
                    po_reg[k]    <= wr_data;
                    po_strobe[k] <= 1'b1;
                end else begin
                    po_strobe[k] <= 1'b0;
                end
            end
            // Two-flop synchroniser per PI word: p0 may go metastable, p1 is what reads see
            for (int j = 0; j < NUM_PI; j++) begin
                pi_sync_p0[j] <= pi[j*DATA_W +: DATA_W];
                pi_sync_p1[j] <= pi_sync_p0[j];
            end
            // Bus write to W beats a concurrent memory load
            if (wr_w) begin
                w_reg <= wr_data;
            end else if (mem_rd_valid) begin
                w_reg <= mem_rd_data;
            end
            mem_conflict <= wr_w && mem_rd_valid;
            wr_err       <= wr_bad;
        end
    end

    function automatic logic [DATA_W-1:0] stored_value(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (sel == ADDR_W'(i)) v = gpr[i];
        end
        for (int j = 0; j < NUM_PI; j++) begin
            if (sel == PI_BASE + ADDR_W'(j)) v = pi_sync_p1[j];
        end
        for (int k = 0; k < NUM_PO; k++) begin
            if (sel == PO_BASE + ADDR_W'(k)) v = po_reg[k];
        end
        if (sel == W_ADDR) v = w_reg;
        return v;
    endfunction

`ifdef REGFILE_BYPASS_EN
    function automatic logic [DATA_W-1:0] forwarded_value(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] v;
        v = stored_value(sel);
        if ((wr_gpr || wr_po || wr_w) && (wr_sel == sel)) begin
            v = wr_data;
        end else if (mem_rd_valid && !wr_w && is_w(sel)) begin
            v = mem_rd_data;
        end
        return v;
    endfunction

    always_comb begin
        rd_a_data = forwarded_value(rd_a_sel);
        rd_b_data = forwarded_value(rd_b_sel);
    end
`else
    always_comb begin
        rd_a_data = stored_value(rd_a_sel);
        rd_b_data = stored_value(rd_b_sel);
    end
`endif

    always_comb begin
        po = '0;
        for (int k = 0; k < NUM_PO; k++) po[k*DATA_W +: DATA_W] = po_reg[k];
    end

    assign w_out = w_reg;

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench for param_register_bank; follows the DUT build when REGFILE_BYPASS_EN is defined.
module tb_param_register_bank;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rd_a_sel, rd_b_sel, wr_sel;
    logic [DATA_W-1:0] rd_a_data, rd_b_data, wr_data, mem_rd_data, w_out;
    logic              wr_en, mem_rd_valid, wr_err, mem_conflict;
    logic [31:0]       pi, po;
    logic [1:0]        po_strobe;

    int pass_cnt = 0;
    int total_cnt = 0;

    param_register_bank dut (
        .clk(clk), .reset(reset),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .pi(pi), .po(po), .po_strobe(po_strobe), .w_out(w_out),
        .wr_err(wr_err), .mem_conflict(mem_conflict)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] got;
        reset = 1'b1; wr_en = 0; wr_sel = 0; wr_data = 0;
        mem_rd_valid = 0; mem_rd_data = 0; pi = 0; rd_a_sel = 0; rd_b_sel = 0;
        step(); step();
        total_cnt++;
        if ({po, po_strobe, wr_err, mem_conflict, w_out} !== 52'd0)
            $display("FAIL reset_outputs: got po=%h strb=%b err=%b conf=%b w=%h, required all 0",
                     po, po_strobe, wr_err, mem_conflict, w_out);
        else pass_cnt++;
        reset = 1'b0;
        for (int a = 0; a < 64; a += 7) begin
            rd_a_sel = ADDR_W'(a); rd_b_sel = ADDR_W'(63 - a);
            #1;
            got = rd_a_data | rd_b_data;
            total_cnt++;
            if (got !== 16'h0) $display("FAIL reset_read_%0d: got %h, required 0000", a, got);
            else pass_cnt++;
        end
        step();
    endtask

    task automatic test_gpr_write();
        wr_en = 1; wr_sel = 5; wr_data = 16'h1234; rd_a_sel = 5; rd_b_sel = 5;
        #1;
        total_cnt++;
        if (rd_a_data !== (BYP ? 16'h1234 : 16'h0000))
            $display("FAIL gpr_same_cycle: got %h, required %h", rd_a_data, BYP ? 16'h1234 : 16'h0000);
        else pass_cnt++;
        step();
        wr_en = 0; wr_data = 0;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h1234 || rd_b_data !== 16'h1234)
            $display("FAIL gpr_read_ab: got a=%h b=%h, required 1234", rd_a_data, rd_b_data);
        else pass_cnt++;
        rd_a_sel = 4; rd_b_sel = 6;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h0 || rd_b_data !== 16'h0)
            $display("FAIL gpr_neighbours: got a=%h b=%h, required 0000", rd_a_data, rd_b_data);
        else pass_cnt++;
        total_cnt++;
        if (wr_err !== 1'b0) $display("FAIL gpr_no_err: got %b, required 0", wr_err);
        else pass_cnt++;
    endtask

    task automatic test_pi_port();
        pi = {16'h0055, 16'h00AA};
        rd_a_sel = 28; rd_b_sel = 29;
        step();
        total_cnt++;
        if (rd_a_data !== 16'h0000)
            $display("FAIL pi_one_edge: got %h, required 0000", rd_a_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rd_a_data !== 16'h00AA || rd_b_data !== 16'h0055)
            $display("FAIL pi_two_edges: got a=%h b=%h, required 00aa 0055", rd_a_data, rd_b_data);
        else pass_cnt++;
        wr_en = 1; wr_sel = 28; wr_data = 16'hBEEF; rd_b_sel = 40;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h00AA)
            $display("FAIL pi_write_not_fwd: got %h, required 00aa", rd_a_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wr_err !== 1'b1) $display("FAIL err_pi_write: got %b, required 1", wr_err);
        else pass_cnt++;
        wr_sel = 40;
        #1;
        total_cnt++;
        if (rd_b_data !== 16'h0000)
            $display("FAIL unmapped_not_fwd: got %h, required 0000", rd_b_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wr_err !== 1'b1) $display("FAIL err_unmapped_write: got %b, required 1", wr_err);
        else pass_cnt++;
        wr_en = 0;
        step();
        total_cnt++;
        if (wr_err !== 1'b0) $display("FAIL err_clears: got %b, required 0", wr_err);
        else pass_cnt++;
        total_cnt++;
        if (rd_a_data !== 16'h00AA || rd_b_data !== 16'h0000)
            $display("FAIL pi_after_writes: got a=%h b=%h, required 00aa 0000", rd_a_data, rd_b_data);
        else pass_cnt++;
    endtask

    task automatic test_po_port();
        wr_en = 1; wr_sel = 30; wr_data = 16'h0F0F;
        step();
        total_cnt++;
        if (po[15:0] !== 16'h0F0F || po_strobe !== 2'b01)
            $display("FAIL po_first_write: got po=%h strb=%b, required 0f0f 01", po[15:0], po_strobe);
        else pass_cnt++;
        step();
        total_cnt++;
        if (po_strobe !== 2'b01)
            $display("FAIL po_repeat_strobe: got %b, required 01", po_strobe);
        else pass_cnt++;
        wr_sel = 31; wr_data = 16'hA5A5;
        step();
        total_cnt++;
        if (po !== 32'hA5A5_0F0F || po_strobe !== 2'b10)
            $display("FAIL po1_write: got po=%h strb=%b, required a5a50f0f 10", po, po_strobe);
        else pass_cnt++;
        wr_en = 0; rd_a_sel = 30; rd_b_sel = 31;
        step();
        total_cnt++;
        if (po_strobe !== 2'b00 || rd_a_data !== 16'h0F0F || rd_b_data !== 16'hA5A5)
            $display("FAIL po_idle: got strb=%b a=%h b=%h, required 00 0f0f a5a5",
                     po_strobe, rd_a_data, rd_b_data);
        else pass_cnt++;
    endtask

    task automatic test_mem_load();
        mem_rd_valid = 1; mem_rd_data = 16'h5555; rd_a_sel = 32;
        #1;
        total_cnt++;
        if (rd_a_data !== (BYP ? 16'h5555 : 16'h0000))
            $display("FAIL mem_fwd: got %h, required %h", rd_a_data, BYP ? 16'h5555 : 16'h0000);
        else pass_cnt++;
        step();
        total_cnt++;
        if (w_out !== 16'h5555 || mem_conflict !== 1'b0)
            $display("FAIL mem_load: got w=%h conf=%b, required 5555 0", w_out, mem_conflict);
        else pass_cnt++;
        mem_rd_data = 16'h1111; wr_en = 1; wr_sel = 32; wr_data = 16'h2222;
        #1;
        total_cnt++;
        if (rd_a_data !== (BYP ? 16'h2222 : 16'h5555))
            $display("FAIL conflict_fwd: got %h, required %h", rd_a_data, BYP ? 16'h2222 : 16'h5555);
        else pass_cnt++;
        step();
        total_cnt++;
        if (w_out !== 16'h2222 || mem_conflict !== 1'b1)
            $display("FAIL conflict: got w=%h conf=%b, required 2222 1", w_out, mem_conflict);
        else pass_cnt++;
        wr_en = 0; mem_rd_valid = 0;
        step();
        total_cnt++;
        if (w_out !== 16'h2222 || mem_conflict !== 1'b0)
            $display("FAIL conflict_clears: got w=%h conf=%b, required 2222 0", w_out, mem_conflict);
        else pass_cnt++;
    endtask

    task automatic test_no_default_write();
        wr_en = 1; wr_sel = 32; wr_data = 16'h00FF;
        step();
        wr_en = 0; wr_data = 16'h0000;
        step();
        step();
        total_cnt++;
        if (w_out !== 16'h00FF || rd_a_data !== 16'h00FF)
            $display("FAIL no_default_write: got w=%h rd=%h, required 00ff", w_out, rd_a_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_sel = 7; wr_data = 16'h0001;
        step();
        wr_data = 16'h0002;
        step();
        wr_en = 0; rd_a_sel = 7;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h0002)
            $display("FAIL back_to_back: got %h, required 0002", rd_a_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_priority();
        reset = 1; wr_en = 1; wr_sel = 3; wr_data = 16'h7777;
        mem_rd_valid = 1; mem_rd_data = 16'h3333;
        step();
        reset = 0; wr_en = 0; mem_rd_valid = 0; rd_a_sel = 3; rd_b_sel = 5;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h0 || rd_b_data !== 16'h0 || w_out !== 16'h0)
            $display("FAIL reset_priority: got g3=%h g5=%h w=%h, required 0", rd_a_data, rd_b_data, w_out);
        else pass_cnt++;
        total_cnt++;
        if (po_strobe !== 2'b00 || wr_err !== 1'b0 || mem_conflict !== 1'b0 || po !== 32'h0)
            $display("FAIL reset_pulses: got strb=%b err=%b conf=%b po=%h, required 0",
                     po_strobe, wr_err, mem_conflict, po);
        else pass_cnt++;
        wr_en = 1; wr_data = 16'h7777;
        step();
        wr_en = 0;
        #1;
        total_cnt++;
        if (rd_a_data !== 16'h7777)
            $display("FAIL write_after_reset: got %h, required 7777", rd_a_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_gpr_write();
        test_pi_port();
        test_po_port();
        test_mem_load();
        test_no_default_write();
        test_back_to_back();
        test_reset_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
